// File: rtl/aes_ct_display_if.sv
// Bus between the AES encryptor / button on one side and the ciphertext display on the other.
// The encryptor side drives valid, ct and btn; the display side returns seg_led, page and loaded.
interface aes_ct_display_if;
   logic         valid;
   logic [127:0] ct;
   logic         btn;
   logic [31:0]  seg_led;
   logic [2:0]   page;
   logic         loaded;

   // valid is a level, not a handshake: a finished block is taken on its rising edge only.
   modport master (output valid, ct, btn, input seg_led, page, loaded);
   modport slave  (input valid, ct, btn, output seg_led, page, loaded);
endinterface

// File: rtl/aes_ct_display.sv
// Captures a 128-bit ciphertext and shows it 16 bits at a time on four 7-segment digits,
// paging forward on each debounced press of an active-low push-button.
module aes_ct_display #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int          CNT_W           = 20
) (
   input logic              clk,
   input logic              rst_n,
   aes_ct_display_if.slave  bus
);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_valid_q;
   logic             r_armed;
   logic [127:0]     r_ct_q;
   logic [2:0]       r_page;
   logic             r_loaded;
   logic             r_sync1;
   logic             r_sync2;
   logic             r_btn_db;
   logic             r_db_q;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_seg;

   logic             w_cap;
   logic             w_press;
   logic [127:0]     w_shift;
   logic [15:0]      w_slice;
   logic [31:0]      w_digits;

   function automatic logic [7:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
         4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
         4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
         4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
      endcase
   endfunction

   // r_armed is low only on the first edge out of reset, so valid held high through
   // reset release is treated as an old block rather than a new rising edge.
   assign w_cap   = bus.valid & ~r_valid_q & r_armed;
   assign w_press = r_db_q & ~r_btn_db;

   // Page 0 is the top 16 bits; shift by (7-page)*16 to bring the slice to the bottom.
   assign w_shift  = r_ct_q >> {~r_page, 4'b0000};
   assign w_slice  = w_shift[15:0];
   assign w_digits = {hex7(w_slice[15:12]), hex7(w_slice[11:8]), hex7(w_slice[7:4]),
                      (r_page == 3'd7) ? (hex7(w_slice[3:0]) & 8'h7F) : hex7(w_slice[3:0])};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_btn_db <= 1'b1;
         r_db_q   <= 1'b1;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= bus.btn;
         r_sync2 <= r_sync1;
         r_db_q  <= r_btn_db;
         if (r_sync2 == r_btn_db) begin
            r_cnt <= '0;
         end else if (r_cnt == C_LAST) begin
            r_btn_db <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_q <= 1'b0;
         r_armed   <= 1'b0;
         r_ct_q    <= '0;
         r_page    <= '0;
         r_loaded  <= 1'b0;
         r_seg     <= 32'hFFFF_FFFF;
      end else begin
         r_valid_q <= bus.valid;
         r_armed   <= 1'b1;
         if (w_cap) begin
            r_ct_q   <= bus.ct;
            r_page   <= '0;
            r_loaded <= 1'b1;
         end else if (w_press && r_loaded) begin
            r_page <= r_page + 3'd1;
         end
         r_seg <= r_loaded ? w_digits : 32'hFFFF_FFFF;
      end
   end

   assign bus.seg_led = r_seg;
   assign bus.page    = r_page;
   assign bus.loaded  = r_loaded;
endmodule

// File: tb/tb_aes_ct_display.sv
// Bench for aes_ct_display: drives captures and button waveforms, predicts every output change
// (cycle and value) from event-level rules, and checks them as the DUT presents them.
module tb_aes_ct_display;
   localparam int D = 8;
   localparam logic [35:0] DARK_T = {32'hFFFF_FFFF, 3'd0, 1'b0};

   logic clk = 1'b0;
   logic rst_n;
   aes_ct_display_if bus ();

   aes_ct_display #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [67:0]  exp_q[$];
   int           tests = 0;
   int           fails = 0;
   logic [31:0]  cyc = 0;

   logic [7:0]   hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Reference state as seen by a user of the board.
   logic [127:0] m_ct;
   int           m_page;
   bit           m_loaded;
   bit           m_db;
   logic [31:0]  p_seg;
   logic [2:0]   p_page;
   logic         p_loaded;

   function automatic logic [31:0] disp(input logic [127:0] v, input int pg, input bit ld);
      logic [127:0] sh;
      int           s;
      logic [31:0]  r;
      if (!ld) return 32'hFFFF_FFFF;
      sh = v >> (16 * (7 - pg));
      s  = int'(sh[15:0]);
      for (int d = 0; d < 4; d++) r[8*d +: 8] = hex_tab[(s / (16 ** d)) % 16];
      if (pg == 7) r[7] = 1'b0;
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] c, input logic [31:0] seg, input logic [2:0] pg,
                       input logic ld);
      if ({seg, pg, ld} != {p_seg, p_page, p_loaded}) exp_q.push_back({c, seg, pg, ld});
      p_seg = seg;
      p_page = pg;
      p_loaded = ld;
   endtask

   task automatic model_reset();
      m_ct = '0;  m_page = 0;  m_loaded = 0;  m_db = 1;
      p_seg = 32'hFFFF_FFFF;  p_page = 3'd0;  p_loaded = 1'b0;
   endtask

   // All driver tasks start and end at a falling edge.
   task automatic btn_run(input logic lvl, input int len);
      logic [31:0] start;
      bus.btn = lvl;
      start = cyc + 1;
      if (lvl != m_db && len >= D) begin
         m_db = lvl;
         if (!lvl && m_loaded) begin
            m_page = (m_page + 1) % 8;
            push(start + D + 2, p_seg, 3'(m_page), 1'b1);
            push(start + D + 3, disp(m_ct, m_page, 1), 3'(m_page), 1'b1);
         end
      end
      repeat (len) @(negedge clk);
   endtask

   task automatic do_capture(input logic [127:0] v, input int hold);
      logic [31:0] e;
      bus.valid = 1'b0;
      @(negedge clk);
      bus.valid = 1'b1;
      bus.ct = v;
      e = cyc + 1;
      m_ct = v;  m_page = 0;  m_loaded = 1;
      push(e, p_seg, 3'd0, 1'b1);
      push(e + 1, disp(v, 0, 1), 3'd0, 1'b1);
      repeat (hold) @(negedge clk);
   endtask

   // Monitor: every visible change of the outputs must be the next predicted one, on its cycle.
   initial begin : monitor
      logic [35:0] last;
      logic [35:0] cur;
      logic [67:0] e;
      last = DARK_T;
      forever begin
         @(posedge clk);
         #1;
         cyc = cyc + 1;
         if (!rst_n) begin
            last = DARK_T;
         end else begin
            cur = {bus.seg_led, bus.page, bus.loaded};
            if (cur != last) begin
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_change: cycle %0d got seg=%h page=%0d loaded=%0b",
                           cyc, cur[35:4], cur[3:1], cur[0]);
               end else begin
                  e = exp_q.pop_front();
                  if (e != {cyc, cur}) begin
                     fails++;
                     $display("FAIL output_change: got cycle %0d seg=%h page=%0d loaded=%0b, expected cycle %0d seg=%h page=%0d loaded=%0b",
                              cyc, cur[35:4], cur[3:1], cur[0], e[67:36], e[35:4], e[3:1], e[0]);
                  end
               end
               last = cur;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      logic [127:0] tv;
      tv = 128'h0123456789ABCDEF_FEDCBA9876543210;
      model_reset();
      rst_n = 1'b0;  bus.valid = 1'b0;  bus.btn = 1'b1;  bus.ct = '0;
      repeat (3) @(negedge clk);
      check("reset_seg", bus.seg_led, 32'hFFFF_FFFF);
      check("reset_page", bus.page, 0);
      check("reset_loaded", bus.loaded, 0);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);

      // Press with nothing captured is ignored.
      btn_run(0, 20);
      btn_run(1, 20);
      check("unloaded_press_seg", bus.seg_led, 32'hFFFF_FFFF);

      do_capture(tv, 50);
      check("capture_seg", bus.seg_led, 32'hC0F9A4B0);

      for (int i = 1; i <= 8; i++) begin
         btn_run(0, 20);
         btn_run(1, 20);
         if (i == 1) check("page1_seg", bus.seg_led, 32'h999282F8);
         if (i == 7) check("page7_seg", bus.seg_led, 32'hB0A4F940);
         if (i == 8) check("wrap_page", bus.page, 0);
      end

      for (int i = 0; i < 10; i++) begin
         btn_run(0, 5);
         btn_run(1, 3);
         btn_run(0, 4);
         btn_run(1, D + 4);
      end
      check("bounce_page", bus.page, 0);

      // Move off page 0, then land a press on the same edge as a new capture.
      btn_run(0, 12);
      btn_run(1, D + 4);
      begin : simultaneous
         logic [31:0] start;
         logic [31:0] e;
         bus.valid = 1'b0;
         bus.btn = 1'b0;
         bus.ct = '1;
         start = cyc + 1;
         repeat (D + 2) @(negedge clk);
         bus.valid = 1'b1;
         e = cyc + 1;
         m_db = 0;  m_ct = '1;  m_page = 0;  m_loaded = 1;
         check("simul_edge_alignment", e, start + D + 2);
         push(e, p_seg, 3'd0, 1'b1);
         push(e + 1, disp(m_ct, 0, 1), 3'd0, 1'b1);
         repeat (3) @(negedge clk);
         btn_run(1, D + 4);
         check("simul_seg", bus.seg_led, 32'h8E8E8E8E);
         check("simul_page", bus.page, 0);
      end

      // Reset mid-display with valid held high: stays dark until valid rises again.
      rst_n = 1'b0;
      #1;
      check("midreset_seg", bus.seg_led, 32'hFFFF_FFFF);
      check("midreset_loaded", bus.loaded, 0);
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("post_reset_seg", bus.seg_led, 32'hFFFF_FFFF);
      check("post_reset_loaded", bus.loaded, 0);
      do_capture(tv, 5);

      for (int r = 0; r < 8; r++) begin
         btn_run(1, D + 4);
         do_capture({$urandom, $urandom, $urandom, $urandom}, $urandom_range(2, 10));
         for (int k = 0; k < 6; k++) begin
            btn_run(0, $urandom_range(2, 20));
            btn_run(1, $urandom_range(2, 20));
         end
      end
      btn_run(1, D + 4);

      repeat (30) @(negedge clk);
      check("queue_drained", 128'(exp_q.size()), 0);
      check("final_state", {bus.seg_led, bus.page, bus.loaded}, {p_seg, p_page, p_loaded});
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
